// File: rtl/da_pkt_pkg.sv
// Shared constants and types for the DA packet dispatcher: header pattern, schedule
// codes, channel bases and FSM states.
package da_pkt_pkg;

    localparam logic [31:0] HDR_MASK = 32'hFF00_00FF;
    localparam logic [31:0] HDR_PAT  = 32'hFF00_00AA;

    localparam logic [15:0] HDR_CODE_CA   = 16'h0000;
    localparam logic [15:0] HDR_CODE_NAV  = 16'h000A;
    localparam logic [15:0] HDR_CODE_BULK = 16'h00AA;

    localparam int NUM_CH = 24;
    localparam int CH_W   = 5;

    localparam logic [CH_W-1:0] CH_CA   = 5'd0;
    localparam logic [CH_W-1:0] CH_NAV  = 5'd8;
    localparam logic [CH_W-1:0] CH_BULK = 5'd16;

    typedef enum logic [2:0] {
        TYPE_NONE = 3'd0,
        TYPE_CA   = 3'd1,
        TYPE_NAV  = 3'd2,
        TYPE_BULK = 3'd3
    } pkt_type_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CA   = 3'd1,
        NAV  = 3'd2,
        BULK = 3'd3,
        DROP = 3'd4
    } state_e;

    typedef struct packed {
        logic      is_hdr;
        pkt_type_e typ;
        logic      unknown;
    } hdr_info_t;

endpackage

// File: rtl/pkt_hdr_decode.sv
// Combinational header classifier: flags header words and maps the type field to a
// schedule code, marking unrecognised type fields as unknown.
module pkt_hdr_decode
    import da_pkt_pkg::*;
(
    input  logic [31:0] din,
    output hdr_info_t   hdr
);

    logic match;

    assign match = (din & HDR_MASK) == HDR_PAT;

    always_comb begin
        hdr.is_hdr  = match;
        hdr.typ     = TYPE_NONE;
        hdr.unknown = 1'b0;
        if (match) begin
            case (din[23:8])
                HDR_CODE_CA:   hdr.typ = TYPE_CA;
                HDR_CODE_NAV:  hdr.typ = TYPE_NAV;
                HDR_CODE_BULK: hdr.typ = TYPE_BULK;
                default:       hdr.unknown = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/da_pack_dispatch.sv
// Routes cache words to the 24 DA channel RAMs according to the schedule set by the
// most recent header packet; outputs are registered one cycle behind the input word.
module da_pack_dispatch
    import da_pkt_pkg::*;
#(
    parameter int DW        = 32,
    parameter int CA_BURST  = 32,
    parameter int NAV_BURST = 10,
    parameter int BULK_PKTS = 8,
    parameter int PKT_WORDS = 256
) (
    input  logic              rdclock,
    input  logic              rst_n,
    input  logic [DW-1:0]     din,
    input  logic              din_valid,
    input  logic              pkt_start,
    output logic [NUM_CH-1:0] wren_out,
    output logic [7:0]        wraddr_out,
    output logic [DW-1:0]     dout,
    output logic [2:0]        pkt_type,
    output logic              busy,
    output logic              err_pulse
);

    localparam int WCW = $clog2(PKT_WORDS + 1);
    localparam int BW  = $clog2(BULK_PKTS + 1);

    hdr_info_t hdr;

    state_e          state, state_nxt;
    pkt_type_e       sched, sched_nxt;
    logic [CH_W-1:0] ch, ch_nxt, start_ch, wr_ch, last_ch;
    logic [WCW-1:0]  wcnt, wcnt_nxt, last_w;
    logic [BW-1:0]   bulk_idx, bidx_nxt;
    logic [7:0]      wr_addr;
    logic            wr, err;

    pkt_hdr_decode u_hdr (
        .din (din[31:0]),
        .hdr (hdr)
    );

    assign last_w  = (state == CA) ? WCW'(CA_BURST - 1) : WCW'(NAV_BURST - 1);
    assign last_ch = (state == CA) ? CH_CA + 5'd7 : CH_NAV + 5'd7;

    always_comb begin
        state_nxt = state;
        sched_nxt = sched;
        ch_nxt    = ch;
        wcnt_nxt  = wcnt;
        bidx_nxt  = bulk_idx;
        start_ch  = CH_CA;
        wr        = 1'b0;
        wr_ch     = ch;
        wr_addr   = wcnt[7:0];
        err       = 1'b0;
        if (din_valid && pkt_start) begin
            // An interrupted bulk packet still uses up its channel slot.
            if (state == BULK) begin
                bidx_nxt = bulk_idx + 1'b1;
                if (bidx_nxt == BW'(BULK_PKTS)) sched_nxt = TYPE_NONE;
            end
            state_nxt = IDLE;
            wcnt_nxt  = '0;
            if (hdr.is_hdr) begin
                if (hdr.unknown) begin
                    err = 1'b1;
                end else begin
                    sched_nxt = hdr.typ;
                    if (hdr.typ == TYPE_BULK) bidx_nxt = '0;
                end
            end else begin
                case (sched_nxt)
                    TYPE_CA: begin
                        state_nxt = CA;
                        start_ch  = CH_CA;
                        sched_nxt = TYPE_NONE;
                    end
                    TYPE_NAV: begin
                        state_nxt = NAV;
                        start_ch  = CH_NAV;
                        sched_nxt = TYPE_NONE;
                    end
                    TYPE_BULK: begin
                        state_nxt = BULK;
                        start_ch  = CH_BULK + CH_W'(bidx_nxt);
                    end
                    default: begin
                        state_nxt = DROP;
                        err       = 1'b1;
                    end
                endcase
                // The first word of a data packet is payload.
                if (state_nxt != DROP) begin
                    wr       = 1'b1;
                    wr_ch    = start_ch;
                    wr_addr  = '0;
                    ch_nxt   = start_ch;
                    wcnt_nxt = WCW'(1);
                end
            end
        end else if (din_valid) begin
            case (state)
                CA, NAV: begin
                    wr = 1'b1;
                    if (wcnt == last_w) begin
                        wcnt_nxt = '0;
                        if (ch == last_ch) state_nxt = DROP;
                        else               ch_nxt    = ch + 5'd1;
                    end else begin
                        wcnt_nxt = wcnt + 1'b1;
                    end
                end
                BULK: begin
                    wr       = 1'b1;
                    wcnt_nxt = (wcnt == WCW'(PKT_WORDS)) ? wcnt : wcnt + 1'b1;
                    if (wcnt == WCW'(PKT_WORDS - 1)) begin
                        state_nxt = DROP;
                        bidx_nxt  = bulk_idx + 1'b1;
                        if (bidx_nxt == BW'(BULK_PKTS)) sched_nxt = TYPE_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge rdclock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sched      <= TYPE_NONE;
            ch         <= '0;
            wcnt       <= '0;
            bulk_idx   <= '0;
            wren_out   <= '0;
            wraddr_out <= '0;
            dout       <= '0;
            err_pulse  <= 1'b0;
        end else begin
            state     <= state_nxt;
            sched     <= sched_nxt;
            ch        <= ch_nxt;
            wcnt      <= wcnt_nxt;
            bulk_idx  <= bidx_nxt;
            wren_out  <= wr ? (NUM_CH'(1) << wr_ch) : '0;
            if (wr) wraddr_out <= wr_addr;
            dout      <= din;
            err_pulse <= err;
        end
    end

    assign pkt_type = sched;
    // Covers the cycle where the last write is still on the outputs after the FSM moved on.
    assign busy = (state == CA) || (state == NAV) || (state == BULK) || (|wren_out);

endmodule
